muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//  Iterative multiply/divide sequencer that owns the HI/LO register pair for the MIPS core.
//  - Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage.
//  - Runs a shift-add multiply or a restoring divide over WIDTH cycles and raises busy so the pipeline stalls.
//  - Drives hi/lo to the MFHI/MFLO path.
// PARAMETERS
//  WIDTH  32  operand width; even, >=4; hi/lo are WIDTH bits each
// PORTS
//  clk    in   1      clock; all state changes on rising edge
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request valid this cycle
//  op     in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//  in0    in   WIDTH  multiplicand / dividend / MTHI-MTLO source
//  in1    in   WIDTH  multiplier / divisor
//  busy   out  1      high while state != IDLE
//  done   out  1      1-cycle pulse: hi/lo hold a new mult/div result
//  hi     out  WIDTH  HI register (product high half / remainder)
//  lo     out  WIDTH  LO register (product low half / quotient)
//  abort  in   1      only when MULDIV_ABORT_EN defined; see CONFIGURATION
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-operation discards the result.
//  Accept: start && !busy at edge T. start while busy is ignored (no queueing, hi/lo untouched).
//  MTHI/MTLO: hi (or lo) <= in0 at edge T. No busy, no done.
//  FSM: IDLE -> PREP -> CALC (WIDTH cycles) -> FIX -> IDLE.
//   PREP (T+1): latch sign flags. Signed ops take |in0|, |in1| in WIDTH-bit wrap arithmetic.
//     DIV/DIVU with in1==0 goes directly to FIX.
//   CALC (T+2..T+WIDTH+1): one product/quotient bit per cycle; counter counts WIDTH-1 down to 0.
//   FIX (T+WIDTH+2): apply sign correction, write hi/lo at the end-of-cycle edge.
//   done=1 and busy=0 in cycle T+WIDTH+3. For WIDTH=32, done is 35 cycles after acceptance.
//  Multiply: 2*WIDTH-bit product. MULT negates the product if the operand signs differ. {hi,lo}=product.
//  Divide: lo=quotient, hi=remainder. DIV negates the quotient if the signs differ.
//   DIV gives the remainder the dividend's sign.
//  Boundaries:
//   - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wrap, no trap).
//   - MULT 0x80000000 * 0x80000000: hi=0x40000000, lo=0.
//   - Divide by zero (any sign): hi=in0 unmodified, lo=all ones, done at T+3.
//  Operands are registered at acceptance; in0/in1 may change while busy.
//  op 6/7 with start: ignored, no state change.
//  done never asserts in the same cycle as busy.
// CONFIGURATION
//  MULDIV_ABORT_EN defined: abort port present.
//   - abort=1 in any non-IDLE cycle: next state IDLE, busy=0 next cycle, no done, hi/lo keep pre-op values.
//   - abort with start in IDLE: abort wins, request dropped.
//  MULDIV_ABORT_EN undefined: no abort port; an accepted op always runs to completion unless rst.
// TESTING
//  1 MULTU ffffffff*ffffffff -> hi=fffffffe lo=00000001; busy cycles T+1..T+34, done at T+35 exactly.
//  2 MULT fffffffd(-3)*00000007 -> hi=ffffffff lo=ffffffeb; MULT 80000000*80000000 -> hi=40000000 lo=0.
//  3 DIV fffffff9(-7)/2 -> lo=fffffffd hi=ffffffff; DIVU 7/2 -> lo=3 hi=1; DIV 80000000/ffffffff -> lo=80000000 hi=0.
//  4 DIVU 00001234/0 -> hi=00001234 lo=ffffffff, done at T+3, busy only T+1..T+2.
//  5 start MULTU, then start DIV and MTHI at T+5 -> both ignored, MULTU result intact; MTLO 0xabcd idle -> lo=abcd next edge.
//  6 rst at T+10 of DIV -> busy=0, hi=lo=0 next cycle, no done; with MULDIV_ABORT_EN, abort at T+10 -> hi/lo unchanged, no done.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute stage and the HI/LO multiply/divide sequencer.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, in0, in1,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, in0, in1,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative shift-add multiply / restoring divide sequencer owning the MIPS HI/LO pair.
// Optional abort port is present when MULDIV_ABORT_EN is defined.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
`ifdef MULDIV_ABORT_EN
    input  logic       abort,
`endif
    muldiv_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        CALC,
        FIX
    } state_t;

    state_t           state;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             is_signed;
    logic             neg_res;
    logic             neg_rem;
    logic             div_zero;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        abs_a     = a_q;
        abs_b     = b_q;
        if (is_signed && a_q[WIDTH-1]) abs_a = -a_q;
        if (is_signed && b_q[WIDTH-1]) abs_b = -b_q;

        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

        // Restoring step: the divisor magnitude never exceeds WIDTH bits, so the
        // shifted partial remainder needs one extra bit and the trial one more for sign.
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd};

        prod_fix  = {acc_hi, acc_lo};
        quo_fix   = acc_lo;
        rem_fix   = acc_hi;
        if (neg_res) begin
            prod_fix = -{acc_hi, acc_lo};
            quo_fix  = -acc_lo;
        end
        if (neg_rem) rem_fix = -acc_hi;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // in this block sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt       <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            div_zero  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            opnd      <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
        end
`ifdef MULDIV_ABORT_EN
        else if (abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end
`endif
        else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                a_q       <= bus.in0;
                                b_q       <= bus.in1;
                                is_div    <= bus.op[1];
                                is_signed <= ~bus.op[0];
                                div_zero  <= 1'b0;
                                state     <= PREP;
                                busy_q    <= 1'b1;
                            end
                            OP_MTHI: hi_q <= bus.in0;
                            OP_MTLO: lo_q <= bus.in0;
                            default: ;
                        endcase
                    end
                end

                PREP: begin
                    neg_res <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_rem <= is_signed & is_div & a_q[WIDTH-1];
                    acc_hi  <= '0;
                    acc_lo  <= is_div ? abs_a : abs_b;
                    opnd    <= is_div ? abs_b : abs_a;
                    if (is_div && b_q == '0) begin
                        div_zero <= 1'b1;
                        state    <= FIX;
                    end else begin
                        cnt   <= CW'(WIDTH - 1);
                        state <= CALC;
                    end
                end

                CALC: begin
                    if (is_div) begin
                        acc_hi <= div_diff[WIDTH+1] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH+1]};
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    end
                    if (cnt == '0) state <= FIX;
                    else           cnt   <= cnt - 1'b1;
                end

                FIX: begin
                    if (div_zero) begin
                        hi_q <= a_q;
                        lo_q <= '1;
                    end else if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (WIDTH=32); abort cases run only with MULDIV_ABORT_EN.
module tb_muldiv_seq;
    localparam int W = 32;

    logic clk;
    logic rst;
`ifdef MULDIV_ABORT_EN
    logic abort;
`endif

    muldiv_seq_if #(.WIDTH(W)) bus ();

    muldiv_seq #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
`ifdef MULDIV_ABORT_EN
        .abort(abort),
`endif
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic s, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = s;
        bus.op    = o;
        bus.in0   = a;
        bus.in1   = b;
    endtask

    // Issue at a negedge; the following posedge is acceptance edge T, and each later
    // negedge k samples cycle T+k.
    task automatic run(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int exp_done,
                       input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input bit inject);
        int k;
        int busy_n;
        int done_at;
        logic busy_at_done;
        @(negedge clk);
        drive(1'b1, o, a, b);
        @(negedge clk);
        drive(1'b0, 3'd7, 32'h0bad_0bad, 32'h0bad_0bad);
        k = 1; busy_n = 0; done_at = 0; busy_at_done = 1'bx;
        while (k <= 60 && done_at == 0) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_at      = k;
                busy_at_done = bus.busy;
            end else begin
                if (inject && k == 4) drive(1'b1, 3'd2, 32'h0000_0064, 32'h0000_0005);
                if (inject && k == 5) drive(1'b1, 3'd4, 32'h5555_5555, 32'h0);
                if (inject && k == 6) drive(1'b0, 3'd7, 32'h0, 32'h0);
                @(negedge clk);
                k++;
            end
        end
        check({tag, " done_cycle"}, 64'(done_at), 64'(exp_done));
        check({tag, " busy_cycles"}, 64'(busy_n), 64'(exp_done - 1));
        check({tag, " busy_at_done"}, {63'b0, busy_at_done}, 64'd0);
        check({tag, " hi"}, {32'b0, bus.hi}, {32'b0, exp_hi});
        check({tag, " lo"}, {32'b0, bus.lo}, {32'b0, exp_lo});
        @(negedge clk);
        check({tag, " done_pulse"}, {63'b0, bus.done}, 64'd0);
    endtask

    // Start an op, then hit it with rst or abort during cycle T+10 and watch for a stray done.
    task automatic kill(input string tag, input bit use_abort,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int seen_done;
        @(negedge clk);
        drive(1'b1, 3'd2, 32'hffff_fff9, 32'h0000_0002);
        @(negedge clk);
        drive(1'b0, 3'd7, 32'h0, 32'h0);
        repeat (9) @(negedge clk);
        if (use_abort) begin
`ifdef MULDIV_ABORT_EN
            abort = 1'b1;
`endif
        end else begin
            rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
`ifdef MULDIV_ABORT_EN
        abort = 1'b0;
`endif
        check({tag, " busy"}, {63'b0, bus.busy}, 64'd0);
        check({tag, " hi"}, {32'b0, bus.hi}, {32'b0, exp_hi});
        check({tag, " lo"}, {32'b0, bus.lo}, {32'b0, exp_lo});
        seen_done = 0;
        repeat (40) begin
            if (bus.done) seen_done++;
            @(negedge clk);
        end
        check({tag, " no_done"}, 64'(seen_done), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
`ifdef MULDIV_ABORT_EN
        abort = 1'b0;
`endif
        drive(1'b0, 3'd7, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset busy", {63'b0, bus.busy}, 64'd0);
        check("reset done", {63'b0, bus.done}, 64'd0);
        check("reset hi", {32'b0, bus.hi}, 64'd0);
        check("reset lo", {32'b0, bus.lo}, 64'd0);

        run("multu_max", 3'd1, 32'hffff_ffff, 32'hffff_ffff, 35, 32'hffff_fffe, 32'h0000_0001, 1'b0);
        run("mult_neg", 3'd0, 32'hffff_fffd, 32'h0000_0007, 35, 32'hffff_ffff, 32'hffff_ffeb, 1'b0);
        run("mult_min", 3'd0, 32'h8000_0000, 32'h8000_0000, 35, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run("div_neg", 3'd2, 32'hffff_fff9, 32'h0000_0002, 35, 32'hffff_ffff, 32'hffff_fffd, 1'b0);
        run("div_negdvsr", 3'd2, 32'h0000_0007, 32'hffff_fffe, 35, 32'h0000_0001, 32'hffff_fffd, 1'b0);
        run("divu", 3'd3, 32'h0000_0007, 32'h0000_0002, 35, 32'h0000_0001, 32'h0000_0003, 1'b0);
        run("div_wrap", 3'd2, 32'h8000_0000, 32'hffff_ffff, 35, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run("divu_zero", 3'd3, 32'h0000_1234, 32'h0000_0000, 3, 32'h0000_1234, 32'hffff_ffff, 1'b0);
        run("div_zero", 3'd2, 32'hffff_fff9, 32'h0000_0000, 3, 32'hffff_fff9, 32'hffff_ffff, 1'b0);
        run("busy_ignore", 3'd1, 32'hffff_ffff, 32'hffff_ffff, 35, 32'hffff_fffe, 32'h0000_0001, 1'b1);

        // MTLO while idle: lo updates at the next edge, hi untouched, no busy/done.
        @(negedge clk);
        drive(1'b1, 3'd5, 32'h0000_abcd, 32'h0);
        @(negedge clk);
        drive(1'b0, 3'd7, 32'h0, 32'h0);
        check("mtlo lo", {32'b0, bus.lo}, 64'h0000_abcd);
        check("mtlo hi", {32'b0, bus.hi}, 64'hffff_fffe);
        check("mtlo busy", {63'b0, bus.busy}, 64'd0);
        check("mtlo done", {63'b0, bus.done}, 64'd0);

        // op 7 with start must not disturb anything.
        @(negedge clk);
        drive(1'b1, 3'd7, 32'h1111_1111, 32'h2222_2222);
        @(negedge clk);
        drive(1'b0, 3'd7, 32'h0, 32'h0);
        check("nop busy", {63'b0, bus.busy}, 64'd0);
        check("nop lo", {32'b0, bus.lo}, 64'h0000_abcd);

`ifdef MULDIV_ABORT_EN
        kill("abort_mid", 1'b1, 32'hffff_fffe, 32'h0000_abcd);
        @(negedge clk);
        drive(1'b1, 3'd5, 32'h0000_7777, 32'h0);
        abort = 1'b1;
        @(negedge clk);
        drive(1'b0, 3'd7, 32'h0, 32'h0);
        abort = 1'b0;
        check("abort_idle lo", {32'b0, bus.lo}, 64'h0000_abcd);
        check("abort_idle busy", {63'b0, bus.busy}, 64'd0);
`endif

        kill("rst_mid", 1'b0, 32'h0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
